// File: rtl/pot_filter_pkg.sv
// pot_filter_pkg -- shared constants and the FSM state type for pot_filter.
//
// Contents:
//   NUM_POTS  number of slider channels (6)
//   POT_W     width of one slider code (12)
//   CH_W      width of the channel index
//   POT_MAX   full-scale slider code (4095)
//   state_t   pot_filter sequencing FSM states
package pot_filter_pkg;

    localparam int NUM_POTS = 6;
    localparam int POT_W    = 12;
    localparam int CH_W     = 3;

    localparam logic [POT_W-1:0] POT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILT = 2'd2,
        CMP  = 2'd3
    } state_t;

endpackage

// File: rtl/pot_filter_iir.sv
// pot_iir_core -- combinational first-order IIR update for one slider channel.
// A single instance is time-shared by all channels of pot_filter.
//
// Parameters:
//   SHIFT     alpha = 1/2^SHIFT
// Ports:
//   primed    in   1             channel already holds a valid accumulator
//   pot       in   POT_W         latched raw slider code
//   acc       in   POT_W+SHIFT   accumulator value to update / to scale down
//   acc_next  out  POT_W+SHIFT   updated accumulator (priming load when !primed)
//   y         out  POT_W         acc scaled back to slider units (acc >> SHIFT)
module pot_iir_core
    import pot_filter_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic                     primed,
    input  logic [POT_W-1:0]         pot,
    input  logic [POT_W+SHIFT-1:0]   acc,
    output logic [POT_W+SHIFT-1:0]   acc_next,
    output logic [POT_W-1:0]         y
);

    localparam int ACC_W = POT_W + SHIFT;

    // One guard bit on top of the accumulator; the result always fits back
    // into ACC_W bits because acc - acc/2^SHIFT + 4095 <= 4095 << SHIFT.
    logic [ACC_W:0] sum;
    logic           sum_unused_msb;

    always_comb begin
        sum = {1'b0, acc} - ({1'b0, acc} >> SHIFT) + {{(SHIFT + 1){1'b0}}, pot};
    end

    assign sum_unused_msb = sum[ACC_W];

    // First visit after reset seeds the accumulator so the output starts at
    // the slider position instead of ramping up from zero.
    assign acc_next = primed ? sum[ACC_W-1:0] : {pot, {SHIFT{1'b0}}};
    assign y        = acc[ACC_W-1:SHIFT];

endmodule

// File: rtl/pot_filter.sv
// pot_filter -- round-robin IIR smoothing with hysteresis for six slider codes.
// Every TICK_DIV clocks one channel is loaded, filtered and compared; the
// filtered value only moves when the change is large enough (or hits a rail).
//
// Build option:
//   POT_FILTER_HYST_EN  defined   -> outputs move when |y - filt| >= HYST, or
//                                    when y differs and sits at 0 or 4095
//                       undefined -> outputs follow y on any change, HYST unused
// Parameters:
//   TICK_DIV  clocks between channel updates (4..65535)
//   SHIFT     IIR coefficient exponent, alpha = 1/2^SHIFT (1..6)
//   HYST      minimum output step in LSBs
// Ports:
//   clk              in   1   system clock
//   rst_n            in   1   asynchronous active-low reset
//   pot_0..pot_5     in   12  raw slider codes, unsigned
//   filt_0..filt_5   out  12  smoothed, gated slider values
//   changed          out  6   bit k high for the cycle in which filt_k is rewritten
//
// FSM states:
//   state | meaning
//   IDLE  | wait for tick
//   LOAD  | latch pot[ch] and acc[ch]
//   FILT  | write IIR result (or priming value) into acc[ch]
//   CMP   | compare y with filt[ch], update filt/changed, advance ch
module pot_filter
    import pot_filter_pkg::*;
#(
    parameter int TICK_DIV = 4096,
    parameter int SHIFT    = 3,
    parameter int HYST     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POT_W-1:0] pot_0,
    input  logic [POT_W-1:0] pot_1,
    input  logic [POT_W-1:0] pot_2,
    input  logic [POT_W-1:0] pot_3,
    input  logic [POT_W-1:0] pot_4,
    input  logic [POT_W-1:0] pot_5,
    output logic [POT_W-1:0] filt_0,
    output logic [POT_W-1:0] filt_1,
    output logic [POT_W-1:0] filt_2,
    output logic [POT_W-1:0] filt_3,
    output logic [POT_W-1:0] filt_4,
    output logic [POT_W-1:0] filt_5,
    output logic [NUM_POTS-1:0] changed
);

    localparam int ACC_W = POT_W + SHIFT;
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_POTS - 1);

`ifdef POT_FILTER_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    // Without hysteresis "any change" is the same as a threshold of one LSB.
    localparam logic [31:0] THRESH = HYST_EN ? 32'(HYST) : 32'd1;

    logic [15:0]       tick_cnt;
    logic              tick;
    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;

    logic [POT_W-1:0]  pot_arr  [NUM_POTS];
    logic [ACC_W-1:0]  acc      [NUM_POTS];
    logic [POT_W-1:0]  filt     [NUM_POTS];
    logic [NUM_POTS-1:0] primed;

    logic [POT_W-1:0]  pot_lat;
    logic [ACC_W-1:0]  acc_lat;

    logic [ACC_W-1:0]  core_acc;
    logic [ACC_W-1:0]  acc_next;
    logic [POT_W-1:0]  y;
    logic [POT_W-1:0]  filt_cur;
    logic [POT_W-1:0]  diff;
    logic              at_rail;
    logic              upd;

    assign pot_arr[0] = pot_0;
    assign pot_arr[1] = pot_1;
    assign pot_arr[2] = pot_2;
    assign pot_arr[3] = pot_3;
    assign pot_arr[4] = pot_4;
    assign pot_arr[5] = pot_5;

    // Free-running tick counter; it keeps counting while a channel is being
    // processed, so with TICK_DIV >= 4 the FSM is always back in IDLE in time.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = LOAD;
            LOAD:    state_nxt = FILT;
            FILT:    state_nxt = CMP;
            CMP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // During CMP the core only provides y from the freshly written acc[ch].
    assign core_acc = (state == CMP) ? acc[ch] : acc_lat;

    pot_iir_core #(
        .SHIFT (SHIFT)
    ) u_core (
        .primed   (primed[ch]),
        .pot      (pot_lat),
        .acc      (core_acc),
        .acc_next (acc_next),
        .y        (y)
    );

    always_comb begin
        filt_cur = filt[ch];
        diff     = (y >= filt_cur) ? (y - filt_cur) : (filt_cur - y);
        at_rail  = (y == '0) || (y == POT_MAX);
        upd      = (state == CMP) && (y != filt_cur) &&
                   ((32'(diff) >= THRESH) || (HYST_EN && at_rail));
    end

    always_comb begin
        changed = '0;
        for (int k = 0; k < NUM_POTS; k++) begin
            changed[k] = upd && (ch == CH_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= '0;
            pot_lat <= '0;
            acc_lat <= '0;
            primed  <= '0;
            for (int k = 0; k < NUM_POTS; k++) begin
                acc[k]  <= '0;
                filt[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    pot_lat <= pot_arr[ch];
                    acc_lat <= acc[ch];
                end
                FILT: begin
                    acc[ch]    <= acc_next;
                    primed[ch] <= 1'b1;
                end
                CMP: begin
                    if (upd) begin
                        filt[ch] <= y;
                    end
                    ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign filt_0 = filt[0];
    assign filt_1 = filt[1];
    assign filt_2 = filt[2];
    assign filt_3 = filt[3];
    assign filt_4 = filt[4];
    assign filt_5 = filt[5];

endmodule

// File: tb/tb_pot_filter.sv
// tb_pot_filter -- self-checking bench for pot_filter (TICK_DIV=8, SHIFT=3, HYST=4).
// Expected behaviour follows POT_FILTER_HYST_EN the same way the design does.
module tb_pot_filter;

    localparam int TD = 8;
    localparam int SH = 3;
    localparam int HY = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pot [6];
    logic [11:0] filt_0, filt_1, filt_2, filt_3, filt_4, filt_5;
    logic [5:0]  changed;

    int errors = 0;
    int checks = 0;

    int m_acc   [6];
    int m_filt  [6];
    bit m_prim  [6];
    int m_ch;

    typedef struct {
        logic [11:0] pot;
        logic [11:0] exp_filt;
        logic        exp_pulse;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    pot_filter #(
        .TICK_DIV (TD),
        .SHIFT    (SH),
        .HYST     (HY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pot_0   (pot[0]),
        .pot_1   (pot[1]),
        .pot_2   (pot[2]),
        .pot_3   (pot[3]),
        .pot_4   (pot[4]),
        .pot_5   (pot[5]),
        .filt_0  (filt_0),
        .filt_1  (filt_1),
        .filt_2  (filt_2),
        .filt_3  (filt_3),
        .filt_4  (filt_4),
        .filt_5  (filt_5),
        .changed (changed)
    );

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 6; k++) begin
            m_acc[k]  = 0;
            m_filt[k] = 0;
            m_prim[k] = 1'b0;
        end
        m_ch = 0;
    endfunction

    // Spec-level reference: exponential smoothing with a 1/8 weight, then
    // an output gate with hysteresis (or plain change detection).
    function automatic bit model_visit(int c, int p);
        int y;
        int d;
        bit move;
        if (!m_prim[c]) begin
            m_acc[c]  = p * 8;
            m_prim[c] = 1'b1;
        end else begin
            m_acc[c] = m_acc[c] - (m_acc[c] / 8) + p;
        end
        y = m_acc[c] / 8;
        d = (y > m_filt[c]) ? y - m_filt[c] : m_filt[c] - y;
`ifdef POT_FILTER_HYST_EN
        move = (y != m_filt[c]) && ((d >= HY) || (y == 0) || (y == 4095));
`else
        move = (y != m_filt[c]);
`endif
        if (move) m_filt[c] = y;
        return move;
    endfunction

    function automatic logic [71:0] dut_filts();
        return {filt_5, filt_4, filt_3, filt_2, filt_1, filt_0};
    endfunction

    function automatic logic [71:0] model_filts();
        return {12'(m_filt[5]), 12'(m_filt[4]), 12'(m_filt[3]),
                12'(m_filt[2]), 12'(m_filt[1]), 12'(m_filt[0])};
    endfunction

    function automatic logic [11:0] dut_filt(int c);
        case (c)
            0:       return filt_0;
            1:       return filt_1;
            2:       return filt_2;
            3:       return filt_3;
            4:       return filt_4;
            default: return filt_5;
        endcase
    endfunction

    // Entry/exit: at a falling edge, 3 rising edges past a tick-counter wrap.
    // The pulse must appear exactly in the 7th sampled cycle (CMP).
    task automatic do_visit(output logic [5:0] obs);
        int         c;
        bit         exp_p;
        logic [5:0] at7;
        logic [5:0] other;
        logic [5:0] exp_vec;
        c       = m_ch;
        exp_p   = model_visit(c, int'(pot[c]));
        at7     = '0;
        other   = '0;
        exp_vec = exp_p ? 6'(32'd1 << c) : 6'd0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 7) at7 = changed;
            else        other = other | changed;
        end
        chk($sformatf("changed_window_ch%0d", c), {60'd0, at7, other}, {60'd0, exp_vec, 6'd0});
        chk($sformatf("filt_all_ch%0d", c), dut_filts(), model_filts());
        m_ch = (m_ch + 1) % 6;
        obs  = at7 | other;
    endtask

    task automatic align_after_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] obs;
        int p2;
        int p3;
        int c;

        tbl[0] = '{12'd2048, 12'd2048, 1'b1};
        tbl[1] = '{12'd0,    12'd0,    1'b0};
        tbl[2] = '{12'd1000, 12'd1000, 1'b1};
        tbl[3] = '{12'd5,    12'd5,    1'b1};
        tbl[4] = '{12'd0,    12'd0,    1'b0};
        tbl[5] = '{12'd0,    12'd0,    1'b0};
        tbl[6] = '{12'd4095, 12'd2303, 1'b1};
        tbl[7] = '{12'd0,    12'd0,    1'b0};

        for (int k = 0; k < 6; k++) pot[k] = 12'd0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_filts", dut_filts(), 72'd0);
        chk("reset_changed", {66'd0, changed}, 72'd0);
        rst_n = 1'b1;
        align_after_reset();

        // Priming, first IIR step, and untouched neighbours.
        for (int i = 0; i < 8; i++) begin
            c = m_ch;
            pot[c] = tbl[i].pot;
            do_visit(obs);
            chk($sformatf("tbl%0d_filt", i), {60'd0, dut_filt(c)}, {60'd0, tbl[i].exp_filt});
            chk($sformatf("tbl%0d_pulse", i), {71'd0, obs[c]}, {71'd0, tbl[i].exp_pulse});
        end

        // Small steady offset on ch2, decay to zero on ch3: 20 visits each.
        pot[2] = 12'd1002;
        pot[3] = 12'd0;
        p2 = 0;
        p3 = 0;
        for (int i = 0; i < 120; i++) begin
            do_visit(obs);
            p2 += int'(obs[2]);
            p3 += int'(obs[3]);
        end
`ifdef POT_FILTER_HYST_EN
        chk("hold_filt2", {60'd0, filt_2}, 72'd1000);
        chk("hold_pulses2", 72'(p2), 72'd0);
        chk("decay_pulses3", 72'(p3), 72'd1);
`else
        chk("hold_filt2", {60'd0, filt_2}, 72'd1002);
        chk("hold_pulses2", 72'(p2), 72'd2);
        chk("decay_pulses3", 72'(p3), 72'd5);
`endif
        chk("decay_filt3", {60'd0, filt_3}, 72'd0);

        // Random slider codes, rails included.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       pot[m_ch] = 12'd0;
                1:       pot[m_ch] = 12'd4095;
                default: pot[m_ch] = 12'($urandom_range(0, 4095));
            endcase
            do_visit(obs);
        end

        // Reset asserted while channel 4 is in FILT.
        pot[0] = 12'd3000;
        while (m_ch != 4) do_visit(obs);
        pot[4] = 12'd2222;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_filts", dut_filts(), model_filts());
        rst_n = 1'b0;
        #1;
        chk("async_reset_filts", dut_filts(), 72'd0);
        chk("async_reset_changed", {66'd0, changed}, 72'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        align_after_reset();
        pot[0] = 12'd777;
        do_visit(obs);
        chk("reprime_filt0", {60'd0, filt_0}, 72'd777);
        chk("reprime_pulse0", {66'd0, obs}, 72'd1);
        do_visit(obs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pot_filter.md
POT_FILTER -- requirements
Module: pot_filter

Interface
REQ-001 Parameter TICK_DIV, default 4096: clock cycles between successive channel updates; legal range 4..65535.
REQ-002 Parameter SHIFT, default 3: IIR coefficient exponent, alpha = 1/2^SHIFT; legal range 1..6.
REQ-003 Parameter HYST, default 4: minimum |change| in LSBs before a filtered output moves.
REQ-004 clk  input  1  system clock; the block uses one clock only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pot_0 .. pot_5  input  12 each  raw slider codes from slider_interface, unsigned.
REQ-007 filt_0 .. filt_5  output  12 each  smoothed, hysteresis-gated slider values, unsigned.
REQ-008 changed  output  6  bit k pulses high for one cycle when filt_k is written with a new value.

Function
REQ-009 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserts for one cycle at count TICK_DIV-1.
REQ-010 Channel index ch SHALL cycle 0,1,2,3,4,5,0,... and advance once per processed tick; channel k is processed on tick 6n+k.
REQ-011 FSM states: IDLE, LOAD, FILT, CMP; IDLE->LOAD on tick, then LOAD->FILT->CMP->IDLE unconditionally, one cycle each.
REQ-012 LOAD SHALL register pot_ch and acc[ch]; the input is sampled only in this cycle.
REQ-013 FILT, primed[ch]=0: acc[ch] <= pot_ch << SHIFT, primed[ch] <= 1.
REQ-014 FILT, primed[ch]=1: acc[ch] <= acc[ch] - (acc[ch] >> SHIFT) + pot_ch, computed in 13+SHIFT bits and stored in 12+SHIFT bits; acc never exceeds 4095 << SHIFT.
REQ-015 CMP: y = acc[ch] >> SHIFT; filt_ch and changed[ch] are updated in this cycle when |y - filt_ch| >= HYST, or when y != filt_ch and y equals 0 or 4095.
REQ-016 changed SHALL rise 3 cycles after tick, with at most one bit set at a time; it is 0 in all other cycles.
REQ-017 The tick counter SHALL run freely during LOAD/FILT/CMP; a tick therefore cannot be lost, given TICK_DIV >= 4.
REQ-018 Unprocessed channels SHALL hold filt and acc unchanged.

Reset
REQ-019 rst_n low SHALL immediately clear filt_0..filt_5, changed, acc[*], primed[*], ch, tick counter and FSM (to IDLE), in any state including mid-FILT.
REQ-020 After release, the first tick SHALL process channel 0 with priming (REQ-013).

Configuration
REQ-021 Macro POT_FILTER_HYST_EN defined: REQ-015 applies as written.
REQ-022 Macro POT_FILTER_HYST_EN undefined: HYST is ignored, and CMP updates filt_ch and pulses changed[ch] whenever y != filt_ch.

Structure
REQ-023 Package pot_filter_pkg SHALL hold NUM_POTS=6, POT_W=12 and the FSM state enum typedef.
REQ-024 Sub-module pot_iir_core SHALL implement the combinational update of REQ-013/014 and y of REQ-015, instanced once and shared across channels.

Verification (bench: TICK_DIV=8, SHIFT=3, HYST=4, macro defined unless stated)
REQ-025 Reset, then pot_0=2048 -> first processing of channel 0: acc=16384, filt_0=2048, changed=6'b000001 for one cycle, 3 cycles after tick.
REQ-026 Continuing from REQ-025, pot_0=4095 on the next channel-0 visit -> acc=18431, filt_0=2303, changed[0] pulses; filt_1..filt_5 are unchanged at that point.
REQ-027 pot_2 primed at 1000, then held at 1002 for 20 visits -> filt_2 stays 1000 and changed[2] never pulses; with the macro undefined, filt_2 steps to 1001, 1002 with pulses.
REQ-028 pot_3 primed at 5, then 0 -> y steps 4,3,...; filt_3 holds 5 until y=0, then filt_3=0 with one pulse.
REQ-029 Drive rst_n low during the FILT state of channel 4 -> all outputs are 0 asynchronously; after release, channel 0 is processed first and re-primed.
